// File: rtl/uc_arbiter_unit.sv
// uc_arbiter_unit: unit-clause arbiter. It checks literals for duplicates and conflicts, then forwards new ones.
//   clk, rst (async, active-high)
//   mem2uca_valid/mem2uca_done/mem2uca : initial unit clauses from memory (LOAD state)
//   eng2uca_valid/eng2uca_empty/eng2uca: literal from the granted engine (ARB state)
//   uca2ucq : accepted new literal, one cycle after sampling (0 = none)
//   engmask : one-hot round-robin engine grant (0 = no grant)
//   conflict: sticky, set once a literal and its negation are both seen
module uc_arbiter_unit #(
    parameter int UC_LENGTH  = 1024,
    parameter int NUM_ENGINE = 4,
    localparam int W  = $clog2(UC_LENGTH) + 1,
    localparam int IW = $clog2(UC_LENGTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem2uca_valid,
    input  logic                  mem2uca_done,
    input  logic signed [W-1:0]   mem2uca,
    input  logic                  eng2uca_valid,
    input  logic                  eng2uca_empty,
    input  logic signed [W-1:0]   eng2uca,
    output logic signed [W-1:0]   uca2ucq,
    output logic [NUM_ENGINE-1:0] engmask,
    output logic                  conflict
);
    typedef enum logic [1:0] {LOAD, ARB, CONFLICT} state_t;
    localparam logic [W-1:0] LIM = W'(UC_LENGTH);
    state_t state, state_next;
    logic [UC_LENGTH-1:0] pos_seen, neg_seen;
    logic [NUM_ENGINE-1:0] grant, grant_next, grant_rot;
    logic signed [W-1:0] cand;
    logic [W-1:0] mag;
    logic [IW-1:0] idx;
    logic cand_valid, neg, in_range, dup, opp, is_new, is_conf;
    // Empty beats valid: an engine reporting empty never has its literal taken.
    always_comb begin
        cand_valid = (state == LOAD) ? mem2uca_valid :
                     (state == ARB)  ? (eng2uca_valid && !eng2uca_empty) : 1'b0;
        cand       = (state == LOAD) ? mem2uca : eng2uca;
        neg        = cand[W-1];
        mag        = neg ? -cand : cand;
        idx        = mag[IW-1:0];
        in_range   = (cand != '0) && (mag < LIM);
        dup        = neg ? neg_seen[idx] : pos_seen[idx];
        opp        = neg ? pos_seen[idx] : neg_seen[idx];
        is_new     = cand_valid && in_range && !dup && !opp;
        is_conf    = cand_valid && in_range && !dup && opp;
    end
    always_comb begin
        grant_rot  = (grant << 1) | (grant >> (NUM_ENGINE - 1));
        grant_next = (state == LOAD) ? (mem2uca_done ? NUM_ENGINE'(1) : '0) :
                     (state == ARB && (eng2uca_empty || eng2uca_valid)) ? grant_rot : grant;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_next;
    end
    always_comb begin
        state_next = is_conf ? CONFLICT : (state == LOAD && mem2uca_done) ? ARB : state;
    end
    always_comb begin
        engmask  = (state == ARB) ? grant : '0;
        conflict = (state == CONFLICT);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_seen <= '0;
            neg_seen <= '0;
            uca2ucq  <= '0;
            grant    <= '0;
        end else begin
            if (is_new && !neg)
                pos_seen[idx] <= 1'b1;
            if (is_new && neg)
                neg_seen[idx] <= 1'b1;
            uca2ucq <= is_new ? cand : '0;
            grant   <= grant_next;
        end
    end
endmodule

// File: tb/tb_uc_arbiter_unit.sv
// tb_uc_arbiter_unit: scoreboard bench for uc_arbiter_unit against a behavioural reference model.
module tb_uc_arbiter_unit;
    localparam int UCL = 1024;
    localparam int NE  = 4;
    localparam int W   = 11;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem2uca_valid = 1'b0, mem2uca_done = 1'b0, eng2uca_valid = 1'b0, eng2uca_empty = 1'b0;
    logic signed [W-1:0] mem2uca = '0, eng2uca = '0;
    logic signed [W-1:0] uca2ucq;
    logic [NE-1:0] engmask;
    logic conflict;
    always #5 clk = ~clk;
    uc_arbiter_unit #(.UC_LENGTH(UCL), .NUM_ENGINE(NE)) dut (
        .clk(clk), .rst(rst),
        .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done), .mem2uca(mem2uca),
        .eng2uca_valid(eng2uca_valid), .eng2uca_empty(eng2uca_empty), .eng2uca(eng2uca),
        .uca2ucq(uca2ucq), .engmask(engmask), .conflict(conflict)
    );
    typedef struct { int q; int m; int c; } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int m_state = 0;
    int m_grant = 0;
    bit m_pos[UCL];
    bit m_neg[UCL];
    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask
    function automatic void model_clear();
        m_state = 0;
        m_grant = 0;
        for (int i = 0; i < UCL; i++) begin
            m_pos[i] = 1'b0;
            m_neg[i] = 1'b0;
        end
    endfunction
    // 0 = ignored or duplicate, 1 = new, 2 = conflict
    function automatic int lit_chk(input int l);
        int a;
        a = (l < 0) ? -l : l;
        if (l == 0 || a >= UCL) return 0;
        if (l > 0 ? m_pos[a] : m_neg[a]) return 0;
        if (l > 0 ? m_neg[a] : m_pos[a]) return 2;
        if (l > 0) m_pos[a] = 1'b1;
        else m_neg[a] = 1'b1;
        return 1;
    endfunction
    task automatic step(input bit mv, input bit md, input int ml, input bit ev, input bit ee, input int el);
        exp_t e;
        int r;
        int out;
        r = 0;
        out = 0;
        @(negedge clk);
        mem2uca_valid = mv;
        mem2uca_done  = md;
        mem2uca       = W'(ml);
        eng2uca_valid = ev;
        eng2uca_empty = ee;
        eng2uca       = W'(el);
        if (m_state == 0) begin
            if (mv) begin
                r = lit_chk(ml);
                if (r == 1) out = ml;
            end
            if (r == 2) m_state = 2;
            else if (md) begin
                m_state = 1;
                m_grant = 0;
            end
        end else if (m_state == 1) begin
            if (ee) m_grant = (m_grant + 1) % NE;
            else if (ev) begin
                r = lit_chk(el);
                if (r == 1) out = el;
                if (r == 2) m_state = 2;
                m_grant = (m_grant + 1) % NE;
            end
        end
        e.q = out;
        e.m = (m_state == 1) ? (1 << m_grant) : 0;
        e.c = (m_state == 2) ? 1 : 0;
        sb.push_back(e);
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        mem2uca_valid = 1'b0;
        mem2uca_done  = 1'b0;
        eng2uca_valid = 1'b0;
        eng2uca_empty = 1'b0;
        model_clear();
        #1;
        chk("rst_uca2ucq", $signed(uca2ucq), 0);
        chk("rst_engmask", engmask, 0);
        chk("rst_conflict", conflict, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("uca2ucq", $signed(uca2ucq), e.q);
                chk("engmask", engmask, e.m);
                chk("conflict", conflict, e.c);
            end
        end
    end
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    initial begin : stim
        int lits[5] = '{0, 1, 2, 3, 4};
        do_reset();
        foreach (lits[i]) step(1, 0, lits[i], 0, 0, 0);
        step(1, 0, 1023, 0, 0, 0);
        step(1, 0, -1024, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 5, 1, 0, 9);
        step(1, 1, 5, 0, 0, 0);
        step(1, 0, 6, 1, 0, 2);
        step(0, 0, 0, 1, 0, 4);
        step(0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 8);
        step(0, 0, 0, 1, 0, 8);
        step(0, 0, 0, 1, 0, 7);
        step(0, 0, 0, 1, 0, -2);
        step(0, 0, 0, 1, 0, 9);
        step(1, 0, 10, 0, 1, 0);
        step(1, 1, 11, 1, 0, 12);
        do_reset();
        step(1, 0, -2, 0, 0, 0);
        step(1, 0, -2, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 3);
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, int'($urandom_range(0, 8)) + 10, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            step(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 16)) - 8);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
